pixel_feed_scheduler: RTL and testbench
=======================================

PIXEL_FEED_SCHEDULER -- requirements
Module: pixel_feed_scheduler

Interface
REQ-001 SHALL have parameter BitSize, default 8, meaning pixel width in bits.
REQ-002 SHALL have parameter ImageWidth, default 16, meaning square image side in pixels; one frame is ImageWidth*ImageWidth pixels.
REQ-003 SHALL have parameter CyclesPerPixel, default 4, meaning minimum cycles between pixels issued to the layer (legal range 1 or more).
REQ-004 SHALL have parameter DrainTimeout, default 1024, meaning maximum DRAIN cycles before a timeout.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all logic uses rising edges.
REQ-006 SHALL have port res_n, input, 1 bit: reset, synchronous and active-high.
REQ-007 SHALL have port frame_start, input, 1 bit: request to start one frame.
REQ-008 SHALL have port abort, input, 1 bit: cancel the current frame.
REQ-009 SHALL have port src_valid, input, 1 bit: source pixel valid.
REQ-010 SHALL have port src_data, input, BitSize bits: source pixel.
REQ-011 SHALL have port src_ready, output, 1 bit: scheduler accepts the pixel this cycle.
REQ-012 SHALL have port layer_in_valid, output, 1 bit: pixel strobe to the conv/pool layer.
REQ-013 SHALL have port layer_in_data, output, BitSize bits: pixel to the layer.
REQ-014 SHALL have port layer_pooling_done, input, 1 bit: the layer has finished all pooling outputs.
REQ-015 SHALL have port busy, output, 1 bit: state is not IDLE.
REQ-016 SHALL have port frame_done, output, 1 bit: one-cycle pulse at frame completion.
REQ-017 SHALL have port pix_count, output, clog2(ImageWidth*ImageWidth+1) bits: pixels issued in the current frame.
REQ-018 SHALL have port err_timeout, output, 1 bit: sticky drain-timeout flag.

Function
REQ-019 SHALL use states IDLE, FEED, DRAIN and DONE.
REQ-020 SHALL move IDLE->FEED on frame_start; frame_start in any other state is ignored and is not queued.
REQ-021 SHALL drive src_ready = (state==FEED) && (pace_cnt==0), combinationally.
REQ-022 SHALL treat src_valid && src_ready as a transfer.
- On a transfer, layer_in_valid=1 and layer_in_data=src_data are registered for exactly one cycle (latency 1).
- Otherwise layer_in_valid=0 and layer_in_data holds its value.
REQ-023 SHALL, on each transfer, load pace_cnt with CyclesPerPixel-1 and increment pix_count; pace_cnt decrements to 0 and saturates there.
- With CyclesPerPixel=1, back-to-back transfers occur every cycle.
REQ-024 SHALL move FEED->DRAIN on the transfer that makes pix_count equal ImageWidth*ImageWidth.
- No further src_ready is asserted in that frame.
REQ-025 SHALL move DRAIN->DONE on the first cycle layer_pooling_done=1; layer_pooling_done in IDLE or FEED is ignored.
REQ-026 SHALL, in DONE, assert frame_done for one cycle, clear pix_count, then go to IDLE.
REQ-027 SHALL, on abort in any non-IDLE state, go to IDLE next cycle.
- Clears pix_count and pace_cnt; no frame_done is produced.
- abort takes priority over a simultaneous transfer, which is then discarded and layer_in_valid stays 0.
REQ-028 SHALL keep pix_count stable while src_valid=0 (a stall); pace_cnt still counts down.

Reset
REQ-029 SHALL, while res_n=1 at a clock edge, set state=IDLE, pace_cnt=0, pix_count=0, layer_in_valid=0, layer_in_data=0, frame_done=0 and err_timeout=0.
- This also applies mid-frame.
- src_ready and busy read 0 during and after reset.

Configuration
REQ-030 SHALL, with macro PIXEL_FEED_SCHEDULER_TIMEOUT_EN defined, count cycles spent in DRAIN.
- If DrainTimeout cycles elapse without layer_pooling_done: set err_timeout (sticky until reset) and go to IDLE without frame_done.
- Without the macro: err_timeout is tied to 0, there is no counter, and DRAIN waits indefinitely.

Verification
REQ-031 SHALL cover a full frame: ImageWidth=4, CyclesPerPixel=4, src_valid held 1 -> 16 layer_in_valid pulses spaced exactly 4 cycles apart, data matches in order; layer_pooling_done asserted 10 cycles after last pixel -> frame_done 1 cycle later, then busy=0.
REQ-032 SHALL cover a stall: src_valid=0 for 7 cycles after pixel 5 -> pix_count stays 5, next pixel accepted on first cycle src_valid returns.
REQ-033 SHALL cover an abort: abort coinciding with transfer of pixel 9 -> no layer_in_valid for that pixel, state IDLE, pix_count=0, frame_done never pulses.
REQ-034 SHALL cover reset mid-FEED: res_n=1 at pixel 3 -> all outputs at reset values next cycle; frame_start then restarts with pix_count from 0.
REQ-035 SHALL cover a timeout with the macro defined: DrainTimeout=8, layer_pooling_done held 0 -> err_timeout=1 after 8 DRAIN cycles, IDLE; without the macro, state remains DRAIN.
REQ-036 SHALL cover CyclesPerPixel=1: 16 pixels are accepted in 16 consecutive cycles.

Source files
------------

// File: rtl/pixel_feed_scheduler.sv
// pixel_feed_scheduler
//
// Paces a stream of source pixels into a conv/pool layer, one square frame
// (ImageWidth*ImageWidth pixels) per frame_start request. Pixels are issued
// no closer than CyclesPerPixel cycles apart. After the last pixel the
// scheduler waits for the layer to report that pooling has finished, pulses
// frame_done and returns to idle.
//
// Ports
//   clk                 rising-edge clock
//   res_n               synchronous, active-high reset
//   frame_start         start one frame (honoured only when idle)
//   abort               cancel the current frame, no frame_done
//   src_valid/src_data  source pixel stream
//   src_ready           pixel accepted this cycle when src_valid is also high
//   layer_in_valid/data registered pixel strobe towards the layer
//   layer_pooling_done  layer has produced all of its pooling outputs
//   busy                scheduler is not idle
//   frame_done          one-cycle pulse when a frame completes
//   pix_count           pixels issued in the current frame
//   err_timeout         sticky drain-timeout flag
//
// Build option
//   PIXEL_FEED_SCHEDULER_TIMEOUT_EN  when defined, DRAIN gives up after
//   DrainTimeout cycles, sets err_timeout and returns to idle. When not
//   defined, err_timeout is tied low and DRAIN waits indefinitely.

module pixel_feed_scheduler #(
    parameter int BitSize        = 8,
    parameter int ImageWidth     = 16,
    parameter int CyclesPerPixel = 4,
    parameter int DrainTimeout   = 1024
) (
    input  logic                                            clk,
    input  logic                                            res_n,
    input  logic                                            frame_start,
    input  logic                                            abort,
    input  logic                                            src_valid,
    input  logic [BitSize-1:0]                              src_data,
    output logic                                            src_ready,
    output logic                                            layer_in_valid,
    output logic [BitSize-1:0]                              layer_in_data,
    input  logic                                            layer_pooling_done,
    output logic                                            busy,
    output logic                                            frame_done,
    output logic [$clog2(ImageWidth*ImageWidth+1)-1:0]      pix_count,
    output logic                                            err_timeout
);

    localparam int PixelsPerFrame = ImageWidth * ImageWidth;
    localparam int CountW         = $clog2(PixelsPerFrame + 1);
    localparam int PaceW          = (CyclesPerPixel > 1) ? $clog2(CyclesPerPixel) : 1;

    localparam logic [CountW-1:0] LastIndex  = CountW'(PixelsPerFrame - 1);
    localparam logic [PaceW-1:0]  PaceReload = PaceW'(CyclesPerPixel - 1);

    typedef enum logic [1:0] {
        IDLE,
        FEED,
        DRAIN,
        DONE
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [PaceW-1:0]   pace_cnt;
    logic               accept;
    logic               last_pixel;
    logic               drain_expired;

    // Reset is folded into the handshake and busy so both read low for the
    // whole time reset is held, not only after the first edge.
    assign src_ready  = !res_n && (state == FEED) && (pace_cnt == '0);
    assign busy       = !res_n && (state != IDLE);

    // An abort in the same cycle as a handshake wins; the pixel is dropped.
    assign accept     = src_valid && src_ready && !abort;
    assign last_pixel = (pix_count == LastIndex);

`ifdef PIXEL_FEED_SCHEDULER_TIMEOUT_EN
    localparam int DrainW = $clog2(DrainTimeout + 1);

    logic [DrainW-1:0] drain_cnt;

    // Counts cycles spent in DRAIN; restarts from zero whenever DRAIN is left.
    always_ff @(posedge clk) begin
        if (res_n) begin
            drain_cnt <= '0;
        end else if (state == DRAIN) begin
            drain_cnt <= drain_cnt + 1'b1;
        end else begin
            drain_cnt <= '0;
        end
    end

    assign drain_expired = (state == DRAIN) && (drain_cnt == DrainW'(DrainTimeout - 1));

    // The error flag only clears on reset so software can see it after the
    // scheduler has already gone back to idle.
    always_ff @(posedge clk) begin
        if (res_n) begin
            err_timeout <= 1'b0;
        end else if (drain_expired && !layer_pooling_done && !abort) begin
            err_timeout <= 1'b1;
        end
    end
`else
    assign drain_expired = 1'b0;
    assign err_timeout   = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (res_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. A late pooling_done still completes the frame even in
    // the cycle the drain timer would expire.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (frame_start) begin
                    state_next = FEED;
                end
            end
            FEED: begin
                if (accept && last_pixel) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (layer_pooling_done) begin
                    state_next = DONE;
                end else if (drain_expired) begin
                    state_next = IDLE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        if (abort && (state != IDLE)) begin
            state_next = IDLE;
        end
    end

    // Datapath: pixel register, pacing counter, pixel counter, done pulse.
    // Every route back to idle (completion, abort, timeout) clears the
    // counters, so a new frame always starts with pace_cnt at zero.
    always_ff @(posedge clk) begin
        if (res_n) begin
            pace_cnt       <= '0;
            pix_count      <= '0;
            layer_in_valid <= 1'b0;
            layer_in_data  <= '0;
            frame_done     <= 1'b0;
        end else begin
            layer_in_valid <= accept;
            if (accept) begin
                layer_in_data <= src_data;
            end
            frame_done <= (state == DRAIN) && (state_next == DONE);
            if (state_next == IDLE) begin
                pace_cnt  <= '0;
                pix_count <= '0;
            end else if (accept) begin
                pace_cnt  <= PaceReload;
                pix_count <= pix_count + 1'b1;
            end else if (pace_cnt != '0) begin
                pace_cnt <= pace_cnt - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pixel_feed_scheduler.sv
// tb_pixel_feed_scheduler
//
// Self-checking bench for pixel_feed_scheduler. Two instances share the
// clock and reset: dut0 uses a 4x4 frame with four cycles per pixel, dut1 a
// 4x4 frame with one cycle per pixel and an 8-cycle drain timeout. A select
// signal routes the bench stimulus to one instance at a time and muxes its
// outputs back for checking.

module tb_pixel_feed_scheduler;

    logic       clk = 1'b0;
    logic       res_n = 1'b1;
    logic       sel = 1'b0;
    logic       fs = 1'b0;
    logic       ab = 1'b0;
    logic       sv = 1'b0;
    logic [7:0] sd = 8'h00;
    logic       pd = 1'b0;

    logic       rdy0, liv0, busy0, fd0, err0;
    logic [7:0] data0;
    logic [4:0] pix0;
    logic       rdy1, liv1, busy1, fd1, err1;
    logic [7:0] data1;
    logic [4:0] pix1;

    logic       o_rdy, o_liv, o_busy, o_fd, o_err;
    logic [7:0] o_data;
    logic [4:0] o_pix;

    int cyc     = 0;
    int checks  = 0;
    int passes  = 0;
    int sent    = 0;
    int lastCyc = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    pixel_feed_scheduler #(
        .BitSize(8), .ImageWidth(4), .CyclesPerPixel(4), .DrainTimeout(1024)
    ) dut0 (
        .clk(clk), .res_n(res_n),
        .frame_start(fs & ~sel), .abort(ab & ~sel),
        .src_valid(sv & ~sel), .src_data(sd), .src_ready(rdy0),
        .layer_in_valid(liv0), .layer_in_data(data0),
        .layer_pooling_done(pd & ~sel),
        .busy(busy0), .frame_done(fd0), .pix_count(pix0), .err_timeout(err0)
    );

    pixel_feed_scheduler #(
        .BitSize(8), .ImageWidth(4), .CyclesPerPixel(1), .DrainTimeout(8)
    ) dut1 (
        .clk(clk), .res_n(res_n),
        .frame_start(fs & sel), .abort(ab & sel),
        .src_valid(sv & sel), .src_data(sd), .src_ready(rdy1),
        .layer_in_valid(liv1), .layer_in_data(data1),
        .layer_pooling_done(pd & sel),
        .busy(busy1), .frame_done(fd1), .pix_count(pix1), .err_timeout(err1)
    );

    assign o_rdy  = sel ? rdy1  : rdy0;
    assign o_liv  = sel ? liv1  : liv0;
    assign o_data = sel ? data1 : data0;
    assign o_busy = sel ? busy1 : busy0;
    assign o_fd   = sel ? fd1   : fd0;
    assign o_pix  = sel ? pix1  : pix0;
    assign o_err  = sel ? err1  : err0;

    typedef struct {
        logic       rst;
        logic       fs;
        logic       ab;
        logic       sv;
        logic [7:0] sd;
        logic       pd;
        logic       eRdy;
        logic       eLiv;
        logic [7:0] eData;
        logic       eBusy;
        logic       eFd;
        logic [4:0] ePix;
    } vec_t;

    vec_t vecs[15];

    // Compare one value and keep the pass/total tally.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual === expected) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got %0d expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Drive one table row onto the inputs of the selected instance.
    task automatic applyStimulus(input vec_t v);
        res_n = v.rst;
        fs    = v.fs;
        ab    = v.ab;
        sv    = v.sv;
        sd    = v.sd;
        pd    = v.pd;
    endtask

    // Hold src_valid high until 'target' pixels have appeared on the layer
    // side, checking data order and, when spacing > 0, the gap between pulses.
    task automatic feedUntil(input int target, input int spacing, input logic [7:0] base);
        int guard = 0;
        sv = 1'b1;
        sd = 8'(base + sent);
        while (sent < target && guard < 300) begin
            @(negedge clk);
            guard++;
            if (o_liv) begin
                checkOutput("pixel data", 32'(o_data), 32'(8'(base + sent)));
                if (sent > 0 && spacing > 0) begin
                    checkOutput("pixel spacing", 32'(cyc - lastCyc), 32'(spacing));
                end
                lastCyc = cyc;
                sent++;
                sd = 8'(base + sent);
            end
        end
        if (sent < target) begin
            checkOutput("pixel count within bound", 32'(sent), 32'(target));
        end
    endtask

    // Wait (bounded) for the selected instance to offer src_ready.
    task automatic waitReady();
        int guard = 0;
        while (!o_rdy && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        checkOutput("src_ready within bound", 32'(o_rdy), 32'd1);
    endtask

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        //           rst   fs    ab    sv    sd      pd    rdy   liv   data    busy  fd    pix
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 5'd0};
        vecs[1]  = '{1'b0, 1'b0, 1'b0, 1'b1, 8'hAA, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 5'd0};
        vecs[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 5'd0};
        vecs[3]  = '{1'b0, 1'b0, 1'b0, 1'b1, 8'h11, 1'b0, 1'b0, 1'b1, 8'h11, 1'b1, 1'b0, 5'd1};
        vecs[4]  = '{1'b0, 1'b0, 1'b0, 1'b1, 8'h22, 1'b0, 1'b0, 1'b0, 8'h11, 1'b1, 1'b0, 5'd1};
        vecs[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 8'h22, 1'b0, 1'b0, 1'b0, 8'h11, 1'b1, 1'b0, 5'd1};
        vecs[6]  = '{1'b0, 1'b0, 1'b0, 1'b1, 8'h22, 1'b0, 1'b1, 1'b0, 8'h11, 1'b1, 1'b0, 5'd1};
        vecs[7]  = '{1'b0, 1'b0, 1'b0, 1'b1, 8'h33, 1'b0, 1'b0, 1'b1, 8'h33, 1'b1, 1'b0, 5'd2};
        vecs[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h33, 1'b0, 1'b0, 1'b0, 8'h33, 1'b1, 1'b0, 5'd2};
        vecs[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h33, 1'b1, 1'b0, 1'b0, 8'h33, 1'b1, 1'b0, 5'd2};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h33, 1'b0, 1'b1, 1'b0, 8'h33, 1'b1, 1'b0, 5'd2};
        vecs[11] = '{1'b0, 1'b0, 1'b1, 1'b1, 8'h44, 1'b0, 1'b0, 1'b0, 8'h33, 1'b0, 1'b0, 5'd0};
        vecs[12] = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h33, 1'b1, 1'b0, 5'd0};
        vecs[13] = '{1'b1, 1'b0, 1'b0, 1'b1, 8'h55, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 5'd0};
        vecs[14] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 5'd0};

        @(negedge clk);

        // Single-cycle behaviour of dut0 from the vector table.
        sel = 1'b0;
        for (int i = 0; i < 15; i++) begin
            applyStimulus(vecs[i]);
            @(negedge clk);
            checkOutput($sformatf("row%0d src_ready", i),      32'(o_rdy),  32'(vecs[i].eRdy));
            checkOutput($sformatf("row%0d layer_in_valid", i), 32'(o_liv),  32'(vecs[i].eLiv));
            checkOutput($sformatf("row%0d layer_in_data", i),  32'(o_data), 32'(vecs[i].eData));
            checkOutput($sformatf("row%0d busy", i),           32'(o_busy), 32'(vecs[i].eBusy));
            checkOutput($sformatf("row%0d frame_done", i),     32'(o_fd),   32'(vecs[i].eFd));
            checkOutput($sformatf("row%0d pix_count", i),      32'(o_pix),  32'(vecs[i].ePix));
        end
        applyStimulus('{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 5'd0});

        // Full frame at four cycles per pixel, pooling done ten cycles later.
        sent = 0;
        fs = 1'b1;
        @(negedge clk);
        fs = 1'b0;
        feedUntil(16, 4, 8'h10);
        sv = 1'b0;
        checkOutput("frame pix_count in drain", 32'(o_pix), 32'd16);
        checkOutput("frame src_ready in drain", 32'(o_rdy), 32'd0);
        repeat (9) @(negedge clk);
        checkOutput("frame busy before pooling", 32'(o_busy), 32'd1);
        checkOutput("frame done before pooling", 32'(o_fd), 32'd0);
        pd = 1'b1;
        @(negedge clk);
        pd = 1'b0;
        checkOutput("frame_done pulse", 32'(o_fd), 32'd1);
        @(negedge clk);
        checkOutput("frame_done one cycle", 32'(o_fd), 32'd0);
        checkOutput("frame busy after done", 32'(o_busy), 32'd0);
        checkOutput("frame pix_count cleared", 32'(o_pix), 32'd0);

        // Stall after pixel 5, then abort on the transfer of pixel 9.
        sent = 0;
        fs = 1'b1;
        @(negedge clk);
        fs = 1'b0;
        feedUntil(5, 4, 8'h20);
        sv = 1'b0;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            checkOutput($sformatf("stall%0d pix_count", i), 32'(o_pix), 32'd5);
        end
        sv = 1'b1;
        sd = 8'h25;
        @(negedge clk);
        checkOutput("resume immediate accept", 32'(o_liv), 32'd1);
        checkOutput("resume data", 32'(o_data), 32'h25);
        checkOutput("resume pix_count", 32'(o_pix), 32'd6);
        sent = 6;
        lastCyc = cyc;
        feedUntil(8, 4, 8'h20);
        sv = 1'b0;
        waitReady();
        ab = 1'b1;
        sv = 1'b1;
        sd = 8'h28;
        @(negedge clk);
        ab = 1'b0;
        sv = 1'b0;
        checkOutput("abort drops pixel", 32'(o_liv), 32'd0);
        checkOutput("abort data held", 32'(o_data), 32'h27);
        checkOutput("abort busy", 32'(o_busy), 32'd0);
        checkOutput("abort pix_count", 32'(o_pix), 32'd0);
        for (int i = 0; i < 3; i++) begin
            checkOutput($sformatf("abort no frame_done%0d", i), 32'(o_fd), 32'd0);
            @(negedge clk);
        end

        // Reset in the middle of FEED, on the transfer of pixel 3.
        sent = 0;
        fs = 1'b1;
        @(negedge clk);
        fs = 1'b0;
        feedUntil(2, 4, 8'h40);
        waitReady();
        res_n = 1'b1;
        @(negedge clk);
        checkOutput("midreset layer_in_valid", 32'(o_liv), 32'd0);
        checkOutput("midreset layer_in_data", 32'(o_data), 32'd0);
        checkOutput("midreset pix_count", 32'(o_pix), 32'd0);
        checkOutput("midreset busy", 32'(o_busy), 32'd0);
        checkOutput("midreset src_ready", 32'(o_rdy), 32'd0);
        checkOutput("midreset frame_done", 32'(o_fd), 32'd0);
        res_n = 1'b0;
        sv = 1'b0;
        fs = 1'b1;
        @(negedge clk);
        fs = 1'b0;
        checkOutput("restart busy", 32'(o_busy), 32'd1);
        checkOutput("restart pix_count", 32'(o_pix), 32'd0);
        sv = 1'b1;
        sd = 8'h50;
        @(negedge clk);
        sv = 1'b0;
        checkOutput("restart first pixel", 32'(o_liv), 32'd1);
        checkOutput("restart first data", 32'(o_data), 32'h50);
        checkOutput("restart pix_count one", 32'(o_pix), 32'd1);
        ab = 1'b1;
        @(negedge clk);
        ab = 1'b0;

        // One cycle per pixel on dut1: 16 pixels in 16 consecutive cycles.
        sel = 1'b1;
        sent = 0;
        fs = 1'b1;
        @(negedge clk);
        fs = 1'b0;
        feedUntil(16, 1, 8'h60);
        sv = 1'b0;
        checkOutput("cpp1 pix_count", 32'(o_pix), 32'd16);
        checkOutput("cpp1 src_ready in drain", 32'(o_rdy), 32'd0);

        // Drain with pooling_done held low.
        repeat (7) @(negedge clk);
        checkOutput("drain busy at 7 cycles", 32'(o_busy), 32'd1);
        checkOutput("drain err at 7 cycles", 32'(o_err), 32'd0);
        @(negedge clk);
`ifdef PIXEL_FEED_SCHEDULER_TIMEOUT_EN
        checkOutput("timeout err_timeout", 32'(o_err), 32'd1);
        checkOutput("timeout busy", 32'(o_busy), 32'd0);
        checkOutput("timeout no frame_done", 32'(o_fd), 32'd0);
        repeat (3) @(negedge clk);
        checkOutput("timeout sticky", 32'(o_err), 32'd1);
`else
        checkOutput("no timeout err_timeout", 32'(o_err), 32'd0);
        checkOutput("no timeout still draining", 32'(o_busy), 32'd1);
        repeat (20) @(negedge clk);
        checkOutput("no timeout long drain", 32'(o_busy), 32'd1);
        pd = 1'b1;
        @(negedge clk);
        pd = 1'b0;
        checkOutput("late pooling frame_done", 32'(o_fd), 32'd1);
        @(negedge clk);
        checkOutput("late pooling idle", 32'(o_busy), 32'd0);
`endif
        res_n = 1'b1;
        @(negedge clk);
        res_n = 1'b0;
        checkOutput("reset clears err_timeout", 32'(o_err), 32'd0);
        checkOutput("reset idle dut1", 32'(o_busy), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
